// File: rtl/split_pipe_pkg.sv
// Shared interconnect definitions: bus widths and field offsets for the native request/response
// buses used by split_pipe and the neighbouring interconnect blocks.
package split_pipe_pkg;

  // Request bus {valid, addr, wdata, wstrb}, wstrb in the LSBs.
  function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response bus {rdata, rvalid, ready}, ready in bit 0.
  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned req_wstrb_off();
    return 0;
  endfunction

  function automatic int unsigned req_wdata_off(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned req_addr_off(input int unsigned data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int unsigned req_valid_off(input int unsigned addr_w,
                                                input int unsigned data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  localparam int unsigned RESP_READY_OFF  = 0;
  localparam int unsigned RESP_RVALID_OFF = 1;
  localparam int unsigned RESP_RDATA_OFF  = 2;

  function automatic int unsigned sel_w_of(input int unsigned n_slaves);
    return (n_slaves > 1) ? $clog2(n_slaves) : 1;
  endfunction

endpackage

// File: rtl/split_err_slave.sv
// Error responder for unmapped accesses: always ready, returns ERR_DATA one cycle after an
// accepted read and pulses err one cycle after any accepted access.
module split_err_slave
  import split_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]  req,
  output logic [resp_w(DATA_W)-1:0]         resp,
  output logic                              err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned V_OFF  = req_valid_off(ADDR_W, DATA_W);

  logic w_valid;
  logic w_read;
  logic w_unused;
  logic r_rvalid;
  logic r_err;

  // req valid is already qualified by the splitter, so valid here means accepted.
  assign w_valid  = req[V_OFF];
  assign w_read   = (req[req_wstrb_off() +: STRB_W] == '0);
  assign w_unused = ^req[V_OFF-1:STRB_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_valid & w_read;
      r_err    <= w_valid;
    end
  end

  assign resp = {DATA_W'(ERR_DATA), r_rvalid, 1'b1};
  assign err  = r_err;

endmodule

// File: rtl/split_pipe.sv
// Pipelined 1-to-N native-bus splitter. Routes requests by an address bit field and steers read
// responses from the slave owning the pending reads; unmapped accesses go to split_err_slave.
module split_pipe
  import split_pipe_pkg::*;
#(
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_W    = sel_w_of(N_SLAVES),
  parameter int unsigned SEL_LSB  = ADDR_W - SEL_W,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]          m_req,
  output logic [resp_w(DATA_W)-1:0]                 m_resp,
  output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0] s_req,
  input  logic [N_SLAVES*resp_w(DATA_W)-1:0]        s_resp,
  output logic                                      err
);

  localparam int unsigned REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int unsigned RESP_W = resp_w(DATA_W);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);

  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic [SEL_W-1:0]  w_sel;
  logic              w_read;
  logic              w_mapped;
  logic              w_cur_mapped;
  logic              w_slv_ready;
  logic              w_slv_rvalid;
  logic [DATA_W-1:0] w_slv_rdata;
  logic              w_rvalid;
  logic [DATA_W-1:0] w_rdata;
  logic              w_drained;
  logic              w_perm;
  logic              w_ready;
  logic              w_inc;
  logic              w_dec;
  logic [REQ_W-1:0]  w_err_req;
  logic [RESP_W-1:0] w_err_resp;

  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_cur_sel;

  assign w_valid  = m_req[req_valid_off(ADDR_W, DATA_W)];
  assign w_addr   = m_req[req_addr_off(DATA_W) +: ADDR_W];
  assign w_wdata  = m_req[req_wdata_off(DATA_W) +: DATA_W];
  assign w_wstrb  = m_req[req_wstrb_off() +: STRB_W];
  assign w_sel    = w_addr[SEL_LSB +: SEL_W];
  assign w_read   = (w_wstrb == '0);
  assign w_mapped     = (32'(w_sel) < N_SLAVES);
  assign w_cur_mapped = (32'(r_cur_sel) < N_SLAVES);

  always_comb begin
    w_slv_ready  = 1'b0;
    w_slv_rvalid = 1'b0;
    w_slv_rdata  = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_slv_ready = s_resp[k*RESP_W + RESP_READY_OFF];
      end
      if (r_cur_sel == SEL_W'(k)) begin
        w_slv_rvalid = s_resp[k*RESP_W + RESP_RVALID_OFF];
        w_slv_rdata  = s_resp[k*RESP_W + RESP_RDATA_OFF +: DATA_W];
      end
    end
  end

  assign w_rvalid = w_cur_mapped ? w_slv_rvalid : w_err_resp[RESP_RVALID_OFF];
  assign w_rdata  = w_cur_mapped ? w_slv_rdata  : w_err_resp[RESP_RDATA_OFF +: DATA_W];

  // The last pending read returning this cycle frees the target, so a switch is taken at once.
  assign w_drained = (r_cnt == '0) | ((r_cnt == CNT_W'(1)) & w_rvalid);
  assign w_perm    = (w_drained | (w_sel == r_cur_sel)) &
                     (~w_read | (r_cnt < CNT_W'(MAX_OUT)));
  assign w_ready   = w_valid & w_perm & (w_mapped ? w_slv_ready : 1'b1);

  always_comb begin
    s_req = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      s_req[k*REQ_W +: REQ_W] = {w_valid & w_perm & (w_sel == SEL_W'(k)),
                                 w_addr, w_wdata, w_wstrb};
    end
  end

  assign w_err_req = {w_valid & w_perm & ~w_mapped, w_addr, w_wdata, w_wstrb};
  assign m_resp    = {w_rdata, w_rvalid, w_ready};

  assign w_inc = w_ready & w_read;
  assign w_dec = w_rvalid & (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_cur_sel <= '0;
    end else begin
      if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_inc && w_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_ready) begin
        r_cur_sel <= w_sel;
      end
    end
  end

  split_err_slave #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ERR_DATA(ERR_DATA)
  ) u_err (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (w_err_req),
    .resp (w_err_resp),
    .err  (err)
  );

endmodule
